// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// No latency (types and constants only).
// No backpressure (no handshakes here).
package md_pkg;

  localparam logic [6:0] OP            = 7'b0110011;
  localparam logic [6:0] OP_32         = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [63:0] DWORD_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] WORD_MIN  = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic is_mul;
    logic is_high;
    logic a_signed;
    logic b_signed;
    logic is_rem;
    logic is_word;
    logic illegal;
  } dec_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// No latency (wires only).
// valid/ready on both the request and the response side.
interface md_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] ir;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] md_out;

  modport master (
    output req_valid, a, b, ir, resp_ready,
    input  req_ready, resp_valid, md_out
  );

  modport slave (
    input  req_valid, a, b, ir, resp_ready,
    output req_ready, resp_valid, md_out
  );
endinterface

// File: rtl/md_decode.sv
// Decodes an instruction word into mul/div control flags.
// Combinational, zero latency.
// No backpressure (pure function of ir).
module md_decode
  import md_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  funct3_t f3;
  logic    unused_ir;

  // Register fields are irrelevant to the operation itself.
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // Map opcode/funct7/funct3 to operation flags; anything else is illegal.
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    f3          = funct3_t'(ir[14:12]);
    if (ir[31:25] == FUNCT7_MULDIV && (ir[6:0] == OP || ir[6:0] == OP_32)) begin
      dec.is_word = (ir[6:0] == OP_32);
      dec.illegal = 1'b0;
      case (f3)
        F3_MUL:    begin dec.is_mul = 1'b1; dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
        F3_MULH:   begin dec.is_mul = 1'b1; dec.is_high = 1'b1; dec.a_signed = 1'b1;
                         dec.b_signed = 1'b1; dec.illegal = dec.is_word; end
        F3_MULHSU: begin dec.is_mul = 1'b1; dec.is_high = 1'b1; dec.a_signed = 1'b1;
                         dec.illegal = dec.is_word; end
        F3_MULHU:  begin dec.is_mul = 1'b1; dec.is_high = 1'b1; dec.illegal = dec.is_word; end
        F3_DIV:    begin dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
        F3_DIVU:   begin end
        F3_REM:    begin dec.is_rem = 1'b1; dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
        F3_REMU:   begin dec.is_rem = 1'b1; end
        default:   dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Handshake to resp_valid: 66 cycles (64-bit), 34 cycles (W), 2 cycles (special cases).
// req_ready only in IDLE; result held in DONE until resp_ready; flush aborts anything.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int W_ITER = 32,
  parameter int D_ITER = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  output logic       busy,
  md_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(D_ITER);

  state_t              state;
  dec_t                dec_in;
  dec_t                op;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    last_cnt;
  logic [2*XLEN-1:0]   acc;    // product accumulator / partial remainder in low half
  logic [2*XLEN-1:0]   opa;    // shifting multiplicand / divisor in low half
  logic [XLEN-1:0]     opb;    // multiplier / dividend-becoming-quotient
  logic                sign_q; // sign of product or quotient
  logic                sign_r; // sign of remainder (dividend sign)
  logic                spec_dz;
  logic                spec_ov;
  logic                unused_op;

  md_decode u_decode (
    .ir  (bus.ir),
    .dec (dec_in)
  );

  assign unused_op = op.a_signed ^ op.b_signed;

  // Operand preparation at request time: extension, magnitudes, special cases.
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            sa, sb, is_div, dz_in, ov_in, special_in;

  always_comb begin
    a_ext = bus.a;
    b_ext = bus.b;
    if (dec_in.is_word) begin
      a_ext = dec_in.a_signed ? sext32(bus.a[31:0]) : {32'b0, bus.a[31:0]};
      b_ext = dec_in.b_signed ? sext32(bus.b[31:0]) : {32'b0, bus.b[31:0]};
    end
    sa         = dec_in.a_signed & a_ext[XLEN-1];
    sb         = dec_in.b_signed & b_ext[XLEN-1];
    a_mag      = sa ? -a_ext : a_ext;
    b_mag      = sb ? -b_ext : b_ext;
    is_div     = !dec_in.is_mul && !dec_in.illegal;
    dz_in      = is_div && (b_ext == '0);
    ov_in      = is_div && dec_in.a_signed && dec_in.b_signed && (b_ext == '1) &&
                 (a_ext == (dec_in.is_word ? WORD_MIN : DWORD_MIN));
    special_in = dec_in.illegal | dz_in | ov_in;
  end

  // One radix-2 step: add-shift for multiply, compare-subtract for divide.
  logic [2*XLEN-1:0] mul_acc;
  logic              bit_in;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic              ge;

  always_comb begin
    mul_acc  = acc + (opb[0] ? opa : '0);
    bit_in   = op.is_word ? opb[31] : opb[XLEN-1];
    rem_sh   = {acc[XLEN-1:0], bit_in};
    rem_sub  = rem_sh - {1'b0, opa[XLEN-1:0]};
    ge       = (rem_sh >= {1'b0, opa[XLEN-1:0]});
    last_cnt = op.is_word ? CNT_W'(W_ITER - 1) : CNT_W'(D_ITER - 1);
  end

  // Result fix-up: sign restore, half select, special-case override, W extension.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, quo_s, rem_s, res, fix_res;

  always_comb begin
    prod  = sign_q ? -acc : acc;
    quo   = op.is_word ? {32'b0, opb[31:0]} : opb;
    quo_s = sign_q ? -quo : quo;
    rem_s = sign_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (op.illegal)      res = '0;
    else if (op.is_mul)  res = op.is_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (spec_dz)    res = op.is_rem ? opb : '1;
    else if (spec_ov)    res = op.is_rem ? '0 : opb;
    else                 res = op.is_rem ? rem_s : quo_s;
    fix_res = op.is_word ? sext32(res[31:0]) : res;
  end

  // Control FSM and datapath registers; flush overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      busy           <= 1'b0;
      bus.md_out     <= '0;
      cnt            <= '0;
      op             <= '0;
      acc            <= '0;
      opa            <= '0;
      opb            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      spec_dz        <= 1'b0;
      spec_ov        <= 1'b0;
    end else if (flush) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      busy           <= 1'b0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op            <= dec_in;
            sign_q        <= sa ^ sb;
            sign_r        <= sa;
            spec_dz       <= dz_in;
            spec_ov       <= ov_in;
            acc           <= '0;
            cnt           <= '0;
            opa           <= {{XLEN{1'b0}}, dec_in.is_mul ? a_mag : b_mag};
            // Special cases keep the extended dividend for the fix-up stage.
            opb           <= special_in ? a_ext : (dec_in.is_mul ? b_mag : a_mag);
            state         <= special_in ? FIX : CALC;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        CALC: begin
          if (op.is_mul) begin
            acc <= mul_acc;
            opa <= {opa[2*XLEN-2:0], 1'b0};
            opb <= {1'b0, opb[XLEN-1:1]};
          end else begin
            acc <= {{XLEN{1'b0}}, (ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0])};
            opb <= {opb[XLEN-2:0], ge};
          end
          cnt <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            state <= FIX;
            cnt   <= '0;
          end
        end
        FIX: begin
          bus.md_out     <= fix_res;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
